i2c_slave_responder: RTL

Synthesizable I2C target (slave) that answers transfers issued by the iicmb I2C master controller on one bus of the multi-bus I2C fabric. It detects START/STOP and repeated START, matches a 7-bit address, ACKs and delivers written bytes on a strobe interface, and fetches read bytes through a request/data handshake. It drives SDA only, as an open-drain output, and never stretches SCL.

---
 rtl/i2c_slave_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 85 ++++++++
 rtl/i2c_slave_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_slave_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_LOAD,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_slv_state_t;

   // Bit position of R/W inside the address byte (1 = read)
   localparam int   RW_BIT = 0;
   // Bus level for acknowledge / not-acknowledge
   localparam logic ACK    = 1'b0;
   localparam logic NACK   = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk_i and produces registered 1-cycle line events.
// The level outputs are delayed to line up with the event pulses, so a consumer
// can sample sda_lvl_o on the same cycle it sees scl_rise_o.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_lvl_o,
   output logic sda_lvl_o,
   output logic start_o,
   output logic stop_o,
   output logic scl_rise_o,
   output logic scl_fall_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic scl_prev_q, sda_prev_q;
   logic scl_s, sda_s;
   logic start_q, start_d, stop_q, stop_d;
   logic rise_q, rise_d, fall_q, fall_d;
   logic scl_lvl_q, sda_lvl_q;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign scl_sync_d[gi] = scl_i;
            assign sda_sync_d[gi] = sda_i;
         end else begin : g_next
            assign scl_sync_d[gi] = scl_sync_q[gi-1];
            assign sda_sync_d[gi] = sda_sync_q[gi-1];
         end
      end
   endgenerate

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Edge/condition detection against the previous synchronized sample
   always_comb begin
      start_d = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_d  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      rise_d  = scl_s & ~scl_prev_q;
      fall_d  = ~scl_s & scl_prev_q;
   end

   // Synchronizer chain, history and event registers (idle bus is high)
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         scl_lvl_q  <= 1'b1;
         sda_lvl_q  <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         start_q    <= start_d;
         stop_q     <= stop_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         scl_lvl_q  <= scl_s;
         sda_lvl_q  <= sda_s;
      end
   end

   assign start_o    = start_q;
   assign stop_o     = stop_q;
   assign scl_rise_o = rise_q;
   assign scl_fall_o = fall_q;
   assign scl_lvl_o  = scl_lvl_q;
   assign sda_lvl_o  = sda_lvl_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, write byte strobe, read byte fetch, open-drain SDA.
// Never stretches SCL; every written byte is ACKed.
module i2c_slave_responder
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR     = 7'h22,
   parameter int         I2C_DATA_WIDTH = 8,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      sda_o,
   output logic                      start_o,
   output logic                      stop_o,
   output logic                      busy_o,
   output logic                      wr_valid_o,
   output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
   output logic                      rd_req_o,
   input  logic [I2C_DATA_WIDTH-1:0] rd_data_i
);

   localparam logic [3:0] LAST_BIT = 4'(I2C_DATA_WIDTH - 1);
   localparam logic [3:0] ALL_BITS = 4'(I2C_DATA_WIDTH);

   logic scl_lvl, sda_lvl, ev_start, ev_stop, ev_rise, ev_fall;

   i2c_line_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_lvl_o (scl_lvl),
      .sda_lvl_o (sda_lvl),
      .start_o   (ev_start),
      .stop_o    (ev_stop),
      .scl_rise_o(ev_rise),
      .scl_fall_o(ev_fall)
   );

   i2c_slv_state_t state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d;
   // phase: second ACK fall pending / rd_data wait cycle done / master ACKed
   logic phase_q, phase_d;
   logic rw_q, rw_d;
   logic sda_q, sda_d;
   logic start_q, start_d, stop_q, stop_d, busy_q, busy_d;
   logic wr_valid_q, wr_valid_d, rd_req_q, rd_req_d;
   logic [I2C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [I2C_DATA_WIDTH-1:0] rx_byte;
   logic addr_match;

   assign rx_byte    = {shift_q[I2C_DATA_WIDTH-2:0], sda_lvl};
   assign addr_match = (rx_byte[7:1] == SLAVE_ADDR);

   // State register and all registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         phase_q    <= 1'b0;
         rw_q       <= 1'b0;
         sda_q      <= 1'b1;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
         rd_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         phase_q    <= phase_d;
         rw_q       <= rw_d;
         sda_q      <= sda_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_data_q  <= wr_data_d;
         rd_req_q   <= rd_req_d;
      end
   end

   // Next state, bit counter and shift register; START/STOP win over data
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      phase_d   = phase_q;
      rw_d      = rw_q;
      if (ev_stop) begin
         state_d = IDLE;
      end else if (ev_start) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ADDR: if (ev_rise) begin
               shift_d = rx_byte;
               if (bit_cnt_q == LAST_BIT) begin
                  if (addr_match) begin
                     state_d = ADDR_ACK;
                     phase_d = 1'b0;
                     rw_d    = rx_byte[RW_BIT];
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            ADDR_ACK, WR_ACK: if (ev_fall) begin
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d   = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = (state_q == WR_ACK || !rw_q) ? WR_DATA : RD_LOAD;
               end
            end
            WR_DATA: if (ev_rise) begin
               shift_d = rx_byte;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = WR_ACK;
                  phase_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            RD_LOAD: begin
               // first cycle: rd_req_o is out; second cycle: rd_data_i is valid
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  state_d = RD_DATA;
                  if (!scl_lvl) begin
                     shift_d   = {rd_data_i[I2C_DATA_WIDTH-2:0], 1'b0};
                     bit_cnt_d = 4'd1;
                  end else begin
                     shift_d   = rd_data_i;
                     bit_cnt_d = '0;
                  end
               end
            end
            RD_DATA: if (ev_fall) begin
               if (bit_cnt_q == ALL_BITS) begin
                  state_d = RD_ACK;
                  phase_d = 1'b0;
               end else begin
                  shift_d   = {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            RD_ACK: begin
               if (ev_rise) begin
                  if (sda_lvl == ACK) phase_d = 1'b1;
                  else                state_d = WAIT_STOP;
               end else if (ev_fall && phase_q) begin
                  state_d = RD_LOAD;
                  phase_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode: SDA drive, strobes, busy flag
   always_comb begin
      sda_d      = sda_q;
      start_d    = 1'b0;
      stop_d     = 1'b0;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_data_d  = wr_data_q;
      rd_req_d   = 1'b0;
      if (ev_stop) begin
         sda_d  = NACK;
         busy_d = 1'b0;
         stop_d = busy_q;
      end else if (ev_start) begin
         sda_d = NACK;
      end else begin
         case (state_q)
            ADDR: if (ev_rise && bit_cnt_q == LAST_BIT) begin
               sda_d   = NACK;
               start_d = addr_match;
               busy_d  = addr_match;
            end
            ADDR_ACK, WR_ACK: if (ev_fall) begin
               sda_d    = phase_q ? NACK : ACK;
               rd_req_d = phase_q && (state_d == RD_LOAD);
            end
            WR_DATA: if (ev_rise && bit_cnt_q == LAST_BIT) begin
               wr_data_d  = rx_byte;
               wr_valid_d = 1'b1;
            end
            RD_LOAD: if (phase_q && !scl_lvl) begin
               sda_d = rd_data_i[I2C_DATA_WIDTH-1];
            end
            RD_DATA: if (ev_fall) begin
               sda_d = (bit_cnt_q == ALL_BITS) ? NACK : shift_q[I2C_DATA_WIDTH-1];
            end
            RD_ACK: begin
               sda_d    = NACK;
               rd_req_d = ev_fall && phase_q;
            end
            default: sda_d = NACK;
         endcase
      end
   end

   assign sda_o      = sda_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;
   assign busy_o     = busy_q;
   assign wr_valid_o = wr_valid_q;
   assign wr_data_o  = wr_data_q;
   assign rd_req_o   = rd_req_q;

endmodule
